// File: rtl/datapath_pkg.sv
// rtl/datapath_pkg.sv - shared op codes, shift codes, sequencer states and status bit indices
// Build option: DATAPATH_SEQ_BYPASS_EN selects the merged LD_AB state.
package datapath_pkg;

    typedef enum logic [1:0] {
        ALU_ADD  = 2'b00,
        ALU_SUB  = 2'b01,
        ALU_AND  = 2'b10,
        ALU_NOTB = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        SH_NONE = 2'b00,
        SH_LSL1 = 2'b01,
        SH_LSR1 = 2'b10,
        SH_ASR1 = 2'b11
    } shift_e;

`ifdef DATAPATH_SEQ_BYPASS_EN
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LD_AB = 3'd1,
        ST_EXEC  = 3'd2,
        ST_WB    = 3'd3
    } state_e;
`else
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LD_A = 3'd1,
        ST_LD_B = 3'd2,
        ST_EXEC = 3'd3,
        ST_WB   = 3'd4
    } state_e;
`endif

    localparam int STAT_Z = 0;
    localparam int STAT_N = 1;
    localparam int STAT_V = 2;

endpackage

// File: rtl/datapath_seq_if.sv
// rtl/datapath_seq_if.sv - command handshake and result bus of the datapath sequencer
// master: issues cmd_* with cmd_valid, sees cmd_ready/done/result/status.
// slave : the sequencer.
interface datapath_seq_if #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_aluop;
    logic [1:0]        cmd_shift;
    logic [REG_AW-1:0] cmd_rn;
    logic [REG_AW-1:0] cmd_rm;
    logic [REG_AW-1:0] cmd_rd;
    logic              cmd_asel;
    logic              cmd_bsel;
    logic [DATA_W-1:0] cmd_imm;
    logic              cmd_wb;
    logic              cmd_loads;
    logic              done;
    logic [DATA_W-1:0] result;
    logic [2:0]        status;

    modport master (
        output cmd_valid, cmd_aluop, cmd_shift, cmd_rn, cmd_rm, cmd_rd,
               cmd_asel, cmd_bsel, cmd_imm, cmd_wb, cmd_loads,
        input  cmd_ready, done, result, status
    );

    modport slave (
        input  cmd_valid, cmd_aluop, cmd_shift, cmd_rn, cmd_rm, cmd_rd,
               cmd_asel, cmd_bsel, cmd_imm, cmd_wb, cmd_loads,
        output cmd_ready, done, result, status
    );
endinterface

// File: rtl/datapath_regfile.sv
// rtl/datapath_regfile.sv - DATA_W x NREGS register file, one write port, asynchronous reads
// Ports: we/waddr/wdata write on clk; raddr0/rdata0 read (raddr1/rdata1 with DATAPATH_SEQ_BYPASS_EN).
// Out-of-range addresses read 0 and never write.
module datapath_regfile #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8,
    parameter int REG_AW = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [REG_AW-1:0] raddr0,
`ifdef DATAPATH_SEQ_BYPASS_EN
    input  logic [REG_AW-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
`endif
    output logic [DATA_W-1:0] rdata0
);
    logic [DATA_W-1:0] mem_q [NREGS];
    logic [DATA_W-1:0] mem_d [NREGS];

    // Address decode by comparison against each real entry, so indices past NREGS match nothing.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            mem_d[i] = (we && (waddr == REG_AW'(i))) ? wdata : mem_q[i];
        end
    end

    always_comb begin
        rdata0 = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (raddr0 == REG_AW'(i)) rdata0 = mem_q[i];
        end
    end

`ifdef DATAPATH_SEQ_BYPASS_EN
    always_comb begin
        rdata1 = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (raddr1 == REG_AW'(i)) rdata1 = mem_q[i];
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end
endmodule

// File: rtl/datapath_seq.sv
// rtl/datapath_seq.sv - micro-sequenced datapath: load A, load B, execute, write back per command
// Ports: clk, rst_n (async active-low), bus (datapath_seq_if.slave: cmd handshake, done, result, status).
// Build option: DATAPATH_SEQ_BYPASS_EN loads A and B on one edge via a second read port.
module datapath_seq
    import datapath_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8,
    parameter int REG_AW = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    datapath_seq_if.slave   bus
);
    localparam int MSB = DATA_W - 1;

    state_e            state_q, state_d;
    alu_op_e           op_q, op_d;
    shift_e            shift_q, shift_d;
    logic [REG_AW-1:0] rn_q, rn_d, rm_q, rm_d, rd_q, rd_d;
    logic              asel_q, asel_d, bsel_q, bsel_d, wb_q, wb_d, loads_q, loads_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
    logic [2:0]        status_q, status_d;
    logic              done_q, done_d;

    logic              rf_we;
    logic [REG_AW-1:0] rf_raddr0;
    logic [DATA_W-1:0] rf_rdata0;
`ifdef DATAPATH_SEQ_BYPASS_EN
    logic [DATA_W-1:0] rf_rdata1;
`endif

    logic [DATA_W-1:0] ain, bin, b_sh, alu_c;
    logic              alu_v;

    datapath_regfile #(.DATA_W(DATA_W), .NREGS(NREGS), .REG_AW(REG_AW)) u_regfile (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (rf_we),
        .waddr  (rd_q),
        .wdata  (c_q),
        .raddr0 (rf_raddr0),
`ifdef DATAPATH_SEQ_BYPASS_EN
        .raddr1 (rm_q),
        .rdata1 (rf_rdata1),
`endif
        .rdata0 (rf_rdata0)
    );

    always_comb begin
        ain = asel_q ? '0 : a_q;
        case (shift_q)
            SH_LSL1: b_sh = {b_q[MSB-1:0], 1'b0};
            SH_LSR1: b_sh = {1'b0, b_q[MSB:1]};
            SH_ASR1: b_sh = {b_q[MSB], b_q[MSB:1]};
            default: b_sh = b_q;
        endcase
        bin = bsel_q ? imm_q : b_sh;

        alu_c = '0;
        alu_v = 1'b0;
        case (op_q)
            ALU_ADD: begin
                alu_c = ain + bin;
                alu_v = (ain[MSB] == bin[MSB]) && (alu_c[MSB] != ain[MSB]);
            end
            ALU_SUB: begin
                alu_c = ain - bin;
                alu_v = (ain[MSB] != bin[MSB]) && (alu_c[MSB] != ain[MSB]);
            end
            ALU_AND:  alu_c = ain & bin;
            default:  alu_c = ~bin;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        shift_d   = shift_q;
        rn_d      = rn_q;
        rm_d      = rm_q;
        rd_d      = rd_q;
        asel_d    = asel_q;
        bsel_d    = bsel_q;
        imm_d     = imm_q;
        wb_d      = wb_q;
        loads_d   = loads_q;
        a_d       = a_q;
        b_d       = b_q;
        c_d       = c_q;
        status_d  = status_q;
        done_d    = 1'b0;
        rf_we     = 1'b0;
        rf_raddr0 = rn_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    op_d    = alu_op_e'(bus.cmd_aluop);
                    shift_d = shift_e'(bus.cmd_shift);
                    rn_d    = bus.cmd_rn;
                    rm_d    = bus.cmd_rm;
                    rd_d    = bus.cmd_rd;
                    asel_d  = bus.cmd_asel;
                    bsel_d  = bus.cmd_bsel;
                    imm_d   = bus.cmd_imm;
                    wb_d    = bus.cmd_wb;
                    loads_d = bus.cmd_loads;
`ifdef DATAPATH_SEQ_BYPASS_EN
                    state_d = ST_LD_AB;
`else
                    state_d = ST_LD_A;
`endif
                end
            end
`ifdef DATAPATH_SEQ_BYPASS_EN
            ST_LD_AB: begin
                a_d     = rf_rdata0;
                b_d     = rf_rdata1;
                state_d = ST_EXEC;
            end
`else
            ST_LD_A: begin
                a_d     = rf_rdata0;
                state_d = ST_LD_B;
            end
            ST_LD_B: begin
                rf_raddr0 = rm_q;
                b_d       = rf_rdata0;
                state_d   = ST_EXEC;
            end
`endif
            ST_EXEC: begin
                c_d = alu_c;
                if (loads_q) begin
                    status_d[STAT_Z] = (alu_c == '0);
                    status_d[STAT_N] = alu_c[MSB];
                    status_d[STAT_V] = alu_v;
                end
                state_d = ST_WB;
            end
            ST_WB: begin
                rf_we   = wb_q;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            op_q     <= ALU_ADD;
            shift_q  <= SH_NONE;
            rn_q     <= '0;
            rm_q     <= '0;
            rd_q     <= '0;
            asel_q   <= 1'b0;
            bsel_q   <= 1'b0;
            imm_q    <= '0;
            wb_q     <= 1'b0;
            loads_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            status_q <= 3'b000;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            shift_q  <= shift_d;
            rn_q     <= rn_d;
            rm_q     <= rm_d;
            rd_q     <= rd_d;
            asel_q   <= asel_d;
            bsel_q   <= bsel_d;
            imm_q    <= imm_d;
            wb_q     <= wb_d;
            loads_q  <= loads_d;
            a_q      <= a_d;
            b_q      <= b_d;
            c_q      <= c_d;
            status_q <= status_d;
            done_q   <= done_d;
        end
    end

    assign bus.cmd_ready = (state_q == ST_IDLE);
    assign bus.done      = done_q;
    assign bus.result    = c_q;
    assign bus.status    = status_q;
endmodule

// File: tb/tb_datapath_seq.sv
// tb/tb_datapath_seq.sv - self-checking bench for datapath_seq against a behavioural model
module tb_datapath_seq;
    localparam int  W   = 16;
    localparam int  NR  = 8;
    localparam longint M = 64'd1 << W;
    localparam longint H = 64'd1 << (W - 1);
`ifdef DATAPATH_SEQ_BYPASS_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 4;
`endif

    typedef struct {
        logic [1:0]  op;
        logic [1:0]  sh;
        logic [2:0]  rn;
        logic [2:0]  rm;
        logic [2:0]  rd;
        logic        asel;
        logic        bsel;
        logic [15:0] imm;
        logic        wb;
        logic        loads;
    } cmd_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    datapath_seq_if #(.DATA_W(W), .REG_AW(3)) bus ();
    datapath_seq #(.DATA_W(W), .NREGS(NR)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int vectors = 0;
    int miscompares = 0;
    longint mreg [NR];
    logic [2:0] mstat;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic cmd_t mk(int op, int sh, int rn, int rm, int rd,
                                int asel, int bsel, int imm, int wb, int loads);
        cmd_t c;
        c.op = 2'(op); c.sh = 2'(sh); c.rn = 3'(rn); c.rm = 3'(rm); c.rd = 3'(rd);
        c.asel = 1'(asel); c.bsel = 1'(bsel); c.imm = 16'(imm);
        c.wb = 1'(wb); c.loads = 1'(loads);
        return c;
    endfunction

    function automatic cmd_t rnd();
        return mk($urandom_range(3), $urandom_range(3), $urandom_range(7), $urandom_range(7),
                  $urandom_range(7), $urandom_range(1), $urandom_range(1),
                  $urandom_range(16'hFFFF), $urandom_range(1), $urandom_range(1));
    endfunction

    task automatic drive(input cmd_t c);
        bus.cmd_aluop = c.op;  bus.cmd_shift = c.sh;
        bus.cmd_rn = c.rn;     bus.cmd_rm = c.rm;     bus.cmd_rd = c.rd;
        bus.cmd_asel = c.asel; bus.cmd_bsel = c.bsel; bus.cmd_imm = c.imm;
        bus.cmd_wb = c.wb;     bus.cmd_loads = c.loads;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) mreg[i] = 0;
        mstat = 3'b000;
    endtask

    // Plain integer arithmetic: wrap modulo 2^W, overflow from true signed range.
    task automatic model(input cmd_t c, output logic [15:0] r, output logic [2:0] st);
        longint a, b, bs, res, sa, sb, sr;
        logic v;
        a = c.asel ? 0 : mreg[c.rn];
        b = mreg[c.rm];
        case (c.sh)
            2'd1:    bs = (b * 2) % M;
            2'd2:    bs = b / 2;
            2'd3:    bs = b / 2 + ((b >= H) ? H : 0);
            default: bs = b;
        endcase
        if (c.bsel) bs = longint'(c.imm);
        sa = (a >= H) ? a - M : a;
        sb = (bs >= H) ? bs - M : bs;
        sr = 0;
        case (c.op)
            2'd0:    begin res = (a + bs) % M;     sr = sa + sb; end
            2'd1:    begin res = (a - bs + M) % M; sr = sa - sb; end
            2'd2:    res = a & bs;
            default: res = (M - 1) - bs;
        endcase
        v = (c.op < 2) && ((sr < -H) || (sr >= H));
        if (c.loads) mstat = {v, (res >= H), (res == 0)};
        if (c.wb) mreg[c.rd] = res;
        r = 16'(res);
        st = mstat;
    endtask

    // Entered 1ns after the accept edge; counts edges until done, checks outcome and pulse width.
    task automatic wait_done(input string tag, input cmd_t c);
        int n;
        logic [15:0] er;
        logic [2:0] es;
        n = 0;
        while (!bus.done && n < 20) begin
            @(posedge clk); #1;
            n++;
            if (!bus.done) check({tag, "_busy_ready"}, 32'(bus.cmd_ready), 32'(0));
        end
        model(c, er, es);
        check({tag, "_latency"}, 32'(n), 32'(LAT));
        check({tag, "_result"}, 32'(bus.result), 32'(er));
        check({tag, "_status"}, 32'(bus.status), 32'(es));
        check({tag, "_ready_at_done"}, 32'(bus.cmd_ready), 32'(1));
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, 32'(bus.done), 32'(0));
    endtask

    task automatic run(input string tag, input cmd_t c);
        @(negedge clk);
        drive(c);
        bus.cmd_valid = 1'b1;
        check({tag, "_ready"}, 32'(bus.cmd_ready), 32'(1));
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        drive(rnd());
        wait_done(tag, c);
    endtask

    initial begin
        cmd_t c1, c2;
        bus.cmd_valid = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_ready", 32'(bus.cmd_ready), 32'(1));
        check("rst_done", 32'(bus.done), 32'(0));
        check("rst_result", 32'(bus.result), 32'(0));
        check("rst_status", 32'(bus.status), 32'(0));

        // immediate loads then register-register ops
        run("ld_r2", mk(0, 0, 0, 0, 2, 1, 1, 32, 1, 1));
        run("ld_r3", mk(0, 0, 0, 0, 3, 1, 1, 42, 1, 1));
        run("add_r5", mk(0, 0, 2, 3, 5, 0, 0, 0, 1, 1));
        check("add_r5_value", 32'(bus.result), 32'd74);
        run("ld_r0", mk(0, 0, 0, 0, 0, 1, 1, 7, 1, 1));
        run("ld_r1", mk(0, 0, 0, 0, 1, 1, 1, 2, 1, 1));
        run("add_lsl", mk(0, 1, 1, 0, 2, 0, 0, 0, 1, 1));
        run("sub_lsr", mk(1, 2, 5, 2, 4, 0, 0, 0, 1, 1));
        check("sub_lsr_value", 32'(bus.result), 32'd66);
        run("ld_r6", mk(0, 0, 0, 0, 6, 1, 1, 16'h8000, 1, 1));
        run("asr", mk(0, 3, 0, 6, 7, 1, 0, 0, 1, 1));
        check("asr_value", 32'(bus.result), 32'hC000);
        run("lsr", mk(0, 2, 0, 6, 7, 1, 0, 0, 1, 1));
        check("lsr_value", 32'(bus.result), 32'h4000);
        run("ld_7fff", mk(0, 0, 0, 0, 1, 1, 1, 16'h7FFF, 1, 1));
        run("ld_one", mk(0, 0, 0, 0, 2, 1, 1, 1, 1, 1));
        run("add_ovf", mk(0, 0, 1, 2, 3, 0, 0, 0, 1, 1));
        check("add_ovf_status", 32'(bus.status), 32'b110);
        run("sub_self", mk(1, 0, 2, 2, 2, 0, 0, 0, 1, 1));
        check("sub_self_status", 32'(bus.status), 32'b001);
        run("not_imm", mk(3, 0, 0, 0, 4, 0, 1, 7, 1, 1));
        check("not_imm_value", 32'(bus.result), 32'hFFF8);

        // second command held on the bus while the first is in flight
        c1 = mk(0, 0, 0, 0, 5, 1, 1, 16'h0123, 1, 1);
        c2 = mk(1, 0, 5, 4, 6, 0, 0, 0, 1, 1);
        @(negedge clk);
        drive(c1);
        bus.cmd_valid = 1'b1;
        @(posedge clk); #1;
        drive(c2);
        wait_done("held_first", c1);
        bus.cmd_valid = 1'b0;
        wait_done("held_second", c2);

        // randomized commands
        for (int i = 0; i < 40; i++) run("rand", rnd());

        // reset during EXEC of a write-back command
        run("ld_r3_pre", mk(0, 0, 0, 0, 3, 1, 1, 16'h1234, 1, 1));
        @(negedge clk);
        drive(mk(0, 0, 0, 0, 3, 1, 1, 16'h0055, 1, 1));
        bus.cmd_valid = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        repeat (LAT - 2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("abort_done", 32'(bus.done), 32'(0));
        check("abort_status", 32'(bus.status), 32'(0));
        check("abort_result", 32'(bus.result), 32'(0));
        @(posedge clk); #1;
        check("abort_done_late", 32'(bus.done), 32'(0));
        @(negedge clk); rst_n = 1'b1;
        model_reset();
        @(posedge clk); #1;
        check("abort_ready", 32'(bus.cmd_ready), 32'(1));
        check("abort_no_done", 32'(bus.done), 32'(0));
        run("readback_r3", mk(0, 0, 0, 3, 0, 1, 0, 0, 0, 1));
        check("readback_r3_zero", 32'(bus.result), 32'(0));
        run("readback_r1", mk(0, 0, 1, 0, 0, 0, 1, 0, 0, 1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
